// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB master.
// Turns a valid/ready request into an APB SETUP/ACCESS transfer and returns a
// one-cycle response. A wait-state timeout stops a dead slave from hanging the bus.
module apb_master_bridge #(
    parameter int DATA_WIDTH      = 32,
    parameter int MAIN_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                       PCLK,
    input  logic                       PRESET_n,
    input  logic                       REQ_VALID,
    output logic                       REQ_READY,
    input  logic                       REQ_WRITE,
    input  logic [MAIN_ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0]      REQ_WDATA,
    input  logic [DATA_WIDTH/8-1:0]    REQ_STRB,
    output logic                       RSP_VALID,
    output logic [DATA_WIDTH-1:0]      RSP_RDATA,
    output logic                       RSP_ERR,
    output logic [MAIN_ADDR_WIDTH-1:0] PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [DATA_WIDTH-1:0]      PWDATA,
    output logic [DATA_WIDTH/8-1:0]    PSTRB,
    input  logic                       PREADY,
    input  logic [DATA_WIDTH-1:0]      PRDATA
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    // One spare count value so TIMEOUT_CYCLES-1 always fits, even for TIMEOUT_CYCLES=1.
    localparam int CNT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_e;

    state_e                       state_q, state_d;
    logic                         req_ready_q, req_ready_d;
    logic                         rsp_valid_q, rsp_valid_d;
    logic                         rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0]        rsp_rdata_q, rsp_rdata_d;
    logic                         psel_q, psel_d;
    logic                         penable_q, penable_d;
    logic                         pwrite_q, pwrite_d;
    logic [MAIN_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]        pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]        pstrb_q, pstrb_d;
    logic [CNT_WIDTH-1:0]         count_q, count_d;

    // Next-state and registered-output logic; the APB address/control hold their value unless a request is accepted.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        count_d     = count_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_ready_q && REQ_VALID) begin
                    state_d   = ST_SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = REQ_WRITE;
                    paddr_d   = REQ_ADDR;
                    pwdata_d  = REQ_WRITE ? REQ_WDATA : '0;
                    pstrb_d   = REQ_WRITE ? REQ_STRB : '0;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
                count_d   = '0;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d     = ST_IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                end else if (count_q == CNT_LAST) begin
                    state_d     = ST_IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset asserts immediately and clears everything, REQ_READY rises on the first edge after release.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            count_q     <= count_d;
        end
    end

    assign REQ_READY = req_ready_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_ERR   = rsp_err_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: self-checking bench for apb_master_bridge.
module tb_apb_master_bridge;

    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int TIMEOUT = 16;

    logic          PCLK;
    logic          PRESET_n;
    logic          REQ_VALID;
    logic          REQ_READY;
    logic          REQ_WRITE;
    logic [AW-1:0] REQ_ADDR;
    logic [DW-1:0] REQ_WDATA;
    logic [3:0]    REQ_STRB;
    logic          RSP_VALID;
    logic [DW-1:0] RSP_RDATA;
    logic          RSP_ERR;
    logic [AW-1:0] PADDR;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [3:0]    PSTRB;
    logic          PREADY;
    logic [DW-1:0] PRDATA;

    int checks = 0;
    int errors = 0;
    int cur_tag = 0;

    // One transfer: request fields, how many wait states the slave inserts, and the expected response.
    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    strb;
        int            waits;
        logic [DW-1:0] prdata;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_t;

    vec_t vecs[7];

    apb_master_bridge #(
        .DATA_WIDTH      (DW),
        .MAIN_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES  (TIMEOUT)
    ) dut (
        .PCLK      (PCLK),
        .PRESET_n  (PRESET_n),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_WRITE (REQ_WRITE),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .REQ_STRB  (REQ_STRB),
        .RSP_VALID (RSP_VALID),
        .RSP_RDATA (RSP_RDATA),
        .RSP_ERR   (RSP_ERR),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Hard time limit so a broken design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model: a slave that waits W cycles answers on ACCESS cycle W+1; more than TIMEOUT cycles means an error.
    function automatic rsp_t refModel(input logic write, input int waits, input logic [DW-1:0] prdata);
        rsp_t r;
        r.err   = (waits >= TIMEOUT);
        r.rdata = (write || r.err) ? '0 : prdata;
        return r;
    endfunction

    // Compare one observed value against its expected value and count it.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s tag=%0d actual=0x%0h required=0x%0h", name, cur_tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge, where outputs are sampled and inputs changed.
    task automatic nextCycle();
        @(posedge PCLK);
        #1;
    endtask

    // Run one complete transfer, playing the slave and checking every cycle from acceptance to the idle cycle after the response.
    task automatic applyStimulus(input vec_t v);
        int            n;
        bit            done;
        logic [DW-1:0] exp_wd;
        logic [3:0]    exp_st;
        exp_wd = v.write ? v.wdata : '0;
        exp_st = v.write ? v.strb : 4'h0;

        REQ_VALID = 1'b1;
        REQ_WRITE = v.write;
        REQ_ADDR  = v.addr;
        REQ_WDATA = v.wdata;
        REQ_STRB  = v.strb;
        n = 0;
        while (REQ_READY !== 1'b1 && n < 20) begin
            nextCycle();
            n++;
        end
        checkOutput("idle_req_ready", REQ_READY, 1);
        nextCycle();

        REQ_VALID = 1'b0;
        REQ_WRITE = 1'($urandom);
        REQ_ADDR  = $urandom;
        REQ_WDATA = $urandom;
        REQ_STRB  = 4'($urandom);
        checkOutput("setup_psel", PSEL, 1);
        checkOutput("setup_penable", PENABLE, 0);
        checkOutput("setup_req_ready", REQ_READY, 0);
        checkOutput("setup_paddr", PADDR, v.addr);
        checkOutput("setup_pwrite", PWRITE, v.write);
        checkOutput("setup_pwdata", PWDATA, exp_wd);
        checkOutput("setup_pstrb", PSTRB, exp_st);
        checkOutput("setup_rsp_valid", RSP_VALID, 0);
        PREADY = 1'($urandom);
        PRDATA = $urandom;
        nextCycle();

        done = 0;
        for (int i = 0; i < TIMEOUT && !done; i++) begin
            checkOutput("access_psel", PSEL, 1);
            checkOutput("access_penable", PENABLE, 1);
            checkOutput("access_req_ready", REQ_READY, 0);
            checkOutput("access_paddr", PADDR, v.addr);
            checkOutput("access_pwrite", PWRITE, v.write);
            checkOutput("access_pwdata", PWDATA, exp_wd);
            checkOutput("access_pstrb", PSTRB, exp_st);
            checkOutput("access_rsp_valid", RSP_VALID, 0);
            PREADY = (i == v.waits);
            PRDATA = (i == v.waits) ? v.prdata : $urandom;
            nextCycle();
            if (i == v.waits || i == TIMEOUT - 1) done = 1;
        end

        PREADY = 1'($urandom);
        PRDATA = $urandom;
        checkOutput("rsp_valid", RSP_VALID, 1);
        checkOutput("rsp_err", RSP_ERR, v.exp_err);
        checkOutput("rsp_rdata", RSP_RDATA, v.exp_rdata);
        checkOutput("rsp_psel", PSEL, 0);
        checkOutput("rsp_penable", PENABLE, 0);
        checkOutput("rsp_req_ready", REQ_READY, 1);
        checkOutput("rsp_paddr_hold", PADDR, v.addr);
        nextCycle();

        checkOutput("post_rsp_valid", RSP_VALID, 0);
        checkOutput("post_psel", PSEL, 0);
        checkOutput("post_paddr_hold", PADDR, v.addr);
        PREADY = 1'b0;
    endtask

    initial begin
        vec_t rv;
        rsp_t rr;

        // Hand-derived directed vectors: zero-wait write, waited read, timeout, and both sides of the timeout boundary.
        vecs[0] = '{1'b1, 32'h8,  32'h0000_00FF, 4'hF, 0,   32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h4,  32'h55AA_55AA, 4'hF, 2,   32'h1234_5678, 1'b0, 32'h1234_5678};
        vecs[2] = '{1'b0, 32'hC,  32'h0,         4'h0, 100, 32'h0,         1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h10, 32'h0,         4'h0, 15,  32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5};
        vecs[4] = '{1'b1, 32'h20, 32'hCAFE_F00D, 4'h5, 15,  32'h7777_7777, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 32'h24, 32'h1357_9BDF, 4'hA, 16,  32'h8888_8888, 1'b1, 32'h0};
        vecs[6] = '{1'b0, 32'h28, 32'hFFFF_FFFF, 4'hF, 14,  32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D};

        PRESET_n  = 1'b0;
        REQ_VALID = 1'b1;
        REQ_WRITE = 1'b1;
        REQ_ADDR  = 32'h40;
        REQ_WDATA = 32'h9999_9999;
        REQ_STRB  = 4'hF;
        PREADY    = 1'b1;
        PRDATA    = 32'h4444_4444;

        // Reset values while reset is held, with a request pending that must be ignored.
        cur_tag = 100;
        repeat (3) nextCycle();
        checkOutput("rst_req_ready", REQ_READY, 0);
        checkOutput("rst_rsp_valid", RSP_VALID, 0);
        checkOutput("rst_rsp_err", RSP_ERR, 0);
        checkOutput("rst_rsp_rdata", RSP_RDATA, 0);
        checkOutput("rst_psel", PSEL, 0);
        checkOutput("rst_penable", PENABLE, 0);
        checkOutput("rst_pwrite", PWRITE, 0);
        checkOutput("rst_paddr", PADDR, 0);
        checkOutput("rst_pwdata", PWDATA, 0);
        checkOutput("rst_pstrb", PSTRB, 0);
        PRESET_n = 1'b1;
        #1;
        checkOutput("rel_req_ready_before_edge", REQ_READY, 0);
        nextCycle();
        checkOutput("rel_req_ready_after_edge", REQ_READY, 1);
        checkOutput("rel_no_accept_psel", PSEL, 0);
        REQ_VALID = 1'b0;
        PREADY    = 1'b0;
        nextCycle();
        checkOutput("rel_idle_psel", PSEL, 0);

        // Directed table.
        for (int k = 0; k < 7; k++) begin
            cur_tag = k;
            applyStimulus(vecs[k]);
        end

        // Back-to-back: REQ_VALID stays high; the second request must wait until the response cycle.
        cur_tag = 200;
        REQ_VALID = 1'b1;
        REQ_WRITE = 1'b1;
        REQ_ADDR  = 32'h0;
        REQ_WDATA = 32'h1111_1111;
        REQ_STRB  = 4'h3;
        checkOutput("b2b_ready", REQ_READY, 1);
        nextCycle();
        checkOutput("b2b_setup1_psel", PSEL, 1);
        checkOutput("b2b_setup1_paddr", PADDR, 32'h0);
        checkOutput("b2b_setup1_pwrite", PWRITE, 1);
        REQ_WRITE = 1'b0;
        REQ_ADDR  = 32'h4;
        REQ_WDATA = 32'h2222_2222;
        REQ_STRB  = 4'hF;
        nextCycle();
        checkOutput("b2b_access1_penable", PENABLE, 1);
        checkOutput("b2b_access1_paddr", PADDR, 32'h0);
        checkOutput("b2b_access1_pwrite", PWRITE, 1);
        checkOutput("b2b_access1_pwdata", PWDATA, 32'h1111_1111);
        checkOutput("b2b_access1_ready", REQ_READY, 0);
        PREADY = 1'b1;
        nextCycle();
        PREADY = 1'b0;
        checkOutput("b2b_rsp1_valid", RSP_VALID, 1);
        checkOutput("b2b_rsp1_rdata", RSP_RDATA, 0);
        checkOutput("b2b_rsp1_ready", REQ_READY, 1);
        checkOutput("b2b_rsp1_psel", PSEL, 0);
        nextCycle();
        REQ_VALID = 1'b0;
        checkOutput("b2b_setup2_psel", PSEL, 1);
        checkOutput("b2b_setup2_penable", PENABLE, 0);
        checkOutput("b2b_setup2_paddr", PADDR, 32'h4);
        checkOutput("b2b_setup2_pwrite", PWRITE, 0);
        checkOutput("b2b_setup2_pstrb", PSTRB, 0);
        checkOutput("b2b_setup2_pwdata", PWDATA, 0);
        checkOutput("b2b_setup2_rsp_valid", RSP_VALID, 0);
        nextCycle();
        PREADY = 1'b1;
        PRDATA = 32'h0000_0ABC;
        nextCycle();
        PREADY = 1'b0;
        checkOutput("b2b_rsp2_valid", RSP_VALID, 1);
        checkOutput("b2b_rsp2_err", RSP_ERR, 0);
        checkOutput("b2b_rsp2_rdata", RSP_RDATA, 32'h0000_0ABC);
        nextCycle();
        checkOutput("b2b_idle_psel", PSEL, 0);
        checkOutput("b2b_idle_rsp_valid", RSP_VALID, 0);

        // Reset asserted mid-ACCESS, between edges: outputs clear at once and no response appears.
        cur_tag = 300;
        REQ_VALID = 1'b1;
        REQ_WRITE = 1'b0;
        REQ_ADDR  = 32'h30;
        nextCycle();
        REQ_VALID = 1'b0;
        PREADY    = 1'b0;
        nextCycle();
        nextCycle();
        checkOutput("mid_access_penable", PENABLE, 1);
        #2;
        PRESET_n = 1'b0;
        #1;
        checkOutput("mid_rst_psel", PSEL, 0);
        checkOutput("mid_rst_penable", PENABLE, 0);
        checkOutput("mid_rst_req_ready", REQ_READY, 0);
        checkOutput("mid_rst_paddr", PADDR, 0);
        checkOutput("mid_rst_rsp_valid", RSP_VALID, 0);
        PREADY = 1'b1;
        nextCycle();
        checkOutput("mid_rst_hold_rsp_valid", RSP_VALID, 0);
        checkOutput("mid_rst_hold_psel", PSEL, 0);
        PRESET_n = 1'b1;
        PREADY   = 1'b0;
        nextCycle();
        checkOutput("mid_rel_rsp_valid", RSP_VALID, 0);
        checkOutput("mid_rel_req_ready", REQ_READY, 1);
        cur_tag = 301;
        applyStimulus(vecs[1]);

        // Randomized transfers checked against the reference model, with random idle gaps.
        for (int k = 0; k < 40; k++) begin
            cur_tag   = 1000 + k;
            rv.write  = 1'($urandom);
            rv.addr   = $urandom;
            rv.wdata  = $urandom;
            rv.strb   = 4'($urandom);
            rv.waits  = $urandom_range(0, 20);
            rv.prdata = $urandom;
            rr = refModel(rv.write, rv.waits, rv.prdata);
            rv.exp_err   = rr.err;
            rv.exp_rdata = rr.rdata;
            applyStimulus(rv);
            repeat ($urandom_range(0, 2)) begin
                PREADY = 1'($urandom);
                PRDATA = $urandom;
                nextCycle();
                checkOutput("gap_psel", PSEL, 0);
                checkOutput("gap_rsp_valid", RSP_VALID, 0);
                checkOutput("gap_paddr_hold", PADDR, rv.addr);
            end
            PREADY = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
